// File: rtl/load_store_unit_if.sv
// Memory-side bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if #(
  parameter int width = 32
) ();
  logic             bus_req;
  logic             bus_we;
  logic [width-1:0] bus_addr;
  logic [width-1:0] bus_wdata;
  logic [3:0]       bus_be;
  logic             bus_ack;
  logic [width-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time through IDLE -> BUS -> RESP.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of force-aligning them.
module load_store_unit #(
  parameter int width = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [width-1:0]  req_addr,
  input  logic [width-1:0]  req_wdata,
  output logic              stall,
  output logic [width-1:0]  load_data,
  output logic              load_valid,
  output logic              fault,
  load_store_unit_if.master bus
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic misalign_trap = 1'b1;
`else
  localparam logic misalign_trap = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state_r;
  logic             we_r;
  logic [2:0]       funct3_r;
  logic [1:0]       off_r;

  logic [1:0]       off_s;
  logic [3:0]       be_s;
  logic [width-1:0] store_data_s;
  logic             legal_s;
  logic [width-1:0] shifted_s;
  logic [width-1:0] load_ext_s;

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Request decode: lane offset (force-aligned by size), byte enables, replicated store data.
  always_comb begin
    off_s        = 2'b00;
    be_s         = 4'b0000;
    store_data_s = {width{1'b0}};
    legal_s      = funct3_legal(req_we, req_funct3) &
                   ~(misalign_trap & misaligned(req_funct3, req_addr[1:0]));
    case (req_funct3[1:0])
      2'b00: begin
        off_s        = req_addr[1:0];
        be_s         = 4'b0001 << off_s;
        store_data_s = {(width/8){req_wdata[7:0]}};
      end
      2'b01: begin
        off_s        = {req_addr[1], 1'b0};
        be_s         = 4'b0011 << off_s;
        store_data_s = {(width/16){req_wdata[15:0]}};
      end
      2'b10: begin
        off_s        = 2'b00;
        be_s         = 4'b1111;
        store_data_s = req_wdata;
      end
      default: begin
        off_s        = 2'b00;
        be_s         = 4'b0000;
        store_data_s = {width{1'b0}};
      end
    endcase
  end

  // Load lane select and sign/zero extension of the acknowledged read word.
  always_comb begin
    shifted_s  = bus.bus_rdata >> {off_r, 3'b000};
    load_ext_s = shifted_s;
    case (funct3_r)
      3'b000:  load_ext_s = {{(width-8){shifted_s[7]}}, shifted_s[7:0]};
      3'b001:  load_ext_s = {{(width-16){shifted_s[15]}}, shifted_s[15:0]};
      3'b010:  load_ext_s = shifted_s;
      3'b100:  load_ext_s = {{(width-8){1'b0}}, shifted_s[7:0]};
      3'b101:  load_ext_s = {{(width-16){1'b0}}, shifted_s[15:0]};
      default: load_ext_s = shifted_s;
    endcase
  end

  // Stall and fault react in the issuing cycle so the core freezes before the next edge.
  always_comb begin
    stall = 1'b0;
    fault = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          stall = legal_s;
          fault = ~legal_s;
        end else begin
          stall = 1'b0;
          fault = 1'b0;
        end
      end
      BUS: begin
        stall = 1'b1;
        fault = 1'b0;
      end
      RESP: begin
        stall = 1'b0;
        fault = 1'b0;
      end
      default: begin
        stall = 1'b0;
        fault = 1'b0;
      end
    endcase
  end

  // Access FSM with registered bus and load-result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      we_r          <= 1'b0;
      funct3_r      <= 3'b000;
      off_r         <= 2'b00;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= {width{1'b0}};
      bus.bus_wdata <= {width{1'b0}};
      bus.bus_be    <= 4'b0000;
      load_data     <= {width{1'b0}};
      load_valid    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          load_valid <= 1'b0;
          if (req_valid && legal_s) begin
            state_r       <= BUS;
            we_r          <= req_we;
            funct3_r      <= req_funct3;
            off_r         <= off_s;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= req_we;
            bus.bus_addr  <= {req_addr[width-1:2], 2'b00};
            bus.bus_wdata <= store_data_s;
            bus.bus_be    <= be_s;
          end else begin
            state_r     <= IDLE;
            bus.bus_req <= 1'b0;
          end
        end
        BUS: begin
          if (bus.bus_ack) begin
            state_r     <= RESP;
            bus.bus_req <= 1'b0;
            if (!we_r) begin
              load_data  <= load_ext_s;
              load_valid <= 1'b1;
            end else begin
              load_valid <= 1'b0;
            end
          end else begin
            state_r <= BUS;
          end
        end
        RESP: begin
          // Any req_valid seen here belongs to the retiring instruction.
          state_r    <= IDLE;
          load_valid <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          bus.bus_req <= 1'b0;
          load_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter `width`, default 32, giving the data and address width.
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port `req_valid`, input, 1 bit: the core presents a memory instruction.
REQ-005 The block SHALL have port `req_we`, input, 1 bit: 1 = store, 0 = load.
REQ-006 The block SHALL have port `req_funct3`, input, 3 bits: the RV32I size/sign code.
REQ-007 The block SHALL have port `req_addr`, input, width bits: the effective byte address.
REQ-008 The block SHALL have port `req_wdata`, input, width bits: the store source (rs2).
REQ-009 The block SHALL have port `stall`, output, 1 bit: freezes PC and the register file.
REQ-010 The block SHALL have port `load_data`, output, width bits: extended load result, feeding the writeback `data_mem` input.
REQ-011 The block SHALL have port `load_valid`, output, 1 bit: `load_data` is valid this cycle.
REQ-012 The block SHALL have port `fault`, output, 1 bit: the access is illegal or misaligned.
REQ-013 The block SHALL have port `bus_req`, output, 1 bit: memory request.
REQ-014 The block SHALL have port `bus_we`, output, 1 bit: memory write enable.
REQ-015 The block SHALL have port `bus_addr`, output, width bits: word-aligned address, {addr[width-1:2],2'b00}.
REQ-016 The block SHALL have port `bus_wdata`, output, width bits: lane-shifted store data.
REQ-017 The block SHALL have port `bus_be`, output, 4 bits: byte enables.
REQ-018 The block SHALL have port `bus_ack`, input, 1 bit: memory completes the current request.
REQ-019 The block SHALL have port `bus_rdata`, input, width bits: read word; valid when `bus_ack`=1.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, BUS and RESP.
REQ-021 In IDLE with `req_valid`=1 and a legal access, the block SHALL register we/funct3/addr/wdata and enter BUS next cycle; `stall`=1 combinationally that cycle.
REQ-022 In BUS, `bus_req`=1 and `stall`=1; `bus_we`/`bus_addr`/`bus_wdata`/`bus_be` SHALL be driven from registers and held stable until `bus_ack`.
REQ-023 In BUS with `bus_ack`=1, the block SHALL register the extended result and enter RESP; an ack in the first BUS cycle SHALL be legal; wait cycles are unbounded.
REQ-024 RESP SHALL last exactly one cycle: `stall`=0; `load_valid`=1 for loads and 0 for stores; the next state is IDLE.
REQ-025 `req_valid` in RESP SHALL be ignored, because it is the same retiring instruction.
REQ-026 Minimum latency SHALL be three cycles, IDLE to RESP inclusive.
REQ-027 Byte enables: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'b1111.
REQ-028 Store data: SB replicates byte[7:0] in all four lanes; SH replicates half[15:0] twice; SW passes the word through.
REQ-029 Loads SHALL select the lane by addr[1:0]: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-030 Legal funct3 SHALL be 000, 001, 010, 100 and 101 for loads, and 000, 001 and 010 for stores; any other funct3 SHALL be illegal.
REQ-031 An illegal access in IDLE SHALL assert `fault` and `stall`=0 for that cycle only, issue no bus request, keep state IDLE, and leave `load_valid`=0.
REQ-032 `load_data` SHALL hold its last value outside RESP.
REQ-033 `bus_rdata` SHALL be ignored when `bus_ack`=0.
REQ-034 `bus_ack` SHALL be ignored outside BUS.

Reset
REQ-035 With `rst`=1 at a rising edge, state SHALL become IDLE from any state, including mid-BUS; the pending access is abandoned.
REQ-036 After reset, `bus_req`=0, `bus_we`=0, `bus_be`=0, `bus_addr`=0, `bus_wdata`=0, `load_data`=0, `load_valid`=0 and `fault`=0.
REQ-037 After reset, `stall` SHALL follow REQ-021 from the first post-reset cycle.

Configuration
REQ-038 Macro `LSU_MISALIGN_TRAP_EN` SHALL control misaligned accesses: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-039 When `LSU_MISALIGN_TRAP_EN` is defined, a misaligned access SHALL be illegal and handled per REQ-031.
REQ-040 When `LSU_MISALIGN_TRAP_EN` is undefined, a misaligned access SHALL be force-aligned (halfword addr[0] treated as 0, word addr[1:0] treated as 0), proceed normally, and never raise `fault` for alignment.

Verification
REQ-041 LW: addr 0x0000_0104, `bus_ack` after 2 wait cycles, rdata 0xDEAD_BEEF -> `bus_addr`=0x104, `bus_be`=1111, RESP with `load_data`=0xDEAD_BEEF and `load_valid`=1, `stall` high for 4 cycles.
REQ-042 LB/LBU: addr 0x0000_0203, rdata 0x80AA_BBCC -> LB `load_data`=0xFFFF_FF80; LBU `load_data`=0x0000_0080.
REQ-043 SB then SH: SB addr 0x0000_0011, wdata 0x1234_56A5 -> `bus_be`=0010, `bus_wdata`=0xA5A5_A5A5; SH addr 0x0000_0012, wdata 0x0000_BEEF -> `bus_be`=1100, `bus_wdata`=0xBEEF_BEEF; `load_valid`=0 in RESP.
REQ-044 Misaligned LW at addr 0x0000_0102 -> with the macro: `fault`=1 for 1 cycle, no `bus_req`; without the macro: `bus_addr`=0x100, normal completion.
REQ-045 `rst` asserted in the 3rd BUS cycle -> next cycle IDLE, `bus_req`=0; a late `bus_ack` is ignored; the next LW completes correctly.
REQ-046 Illegal funct3 011, load -> `fault`=1, `stall`=0, no `bus_req`, state IDLE.
